drop_controller: RTL

Game-move sequencer for the Connect-4 board frame memory. Accepts one column request per move and tracks column heights and a 7x6 occupancy model. Converts each accepted move into a single-cycle write strobe, column select and row address for the coin-painting memory. After every placement it scans the landed cell for four-in-a-row, raises the win or draw flags, and alternates the active player.

---
 rtl/connect4_pkg.sv | 56 +++++
 rtl/drop_controller_if.sv | 29 ++
 rtl/connect4_win_scanner.sv | 147 ++++++++++++++
 rtl/drop_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 move sequencer and its win scanner.
package connect4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int MAX_MOVES = NUM_COLS * NUM_ROWS;

    // Cell encoding is identical to the coin encoding of the frame memory.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        SCAN  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Scan directions, probed in this order.
    typedef enum logic [1:0] {
        DIR_HORZ    = 2'd0,
        DIR_VERT    = 2'd1,
        DIR_DIAG_UP = 2'd2,
        DIR_DIAG_DN = 2'd3
    } dir_t;

    localparam logic signed [1:0] DELTA_POS  = 2'sb01;
    localparam logic signed [1:0] DELTA_ZERO = 2'sb00;
    localparam logic signed [1:0] DELTA_NEG  = 2'sb11;

    // Column step of a direction's positive ray.
    function automatic logic signed [1:0] dir_dc(input logic [1:0] dir);
        return (dir == DIR_VERT) ? DELTA_ZERO : DELTA_POS;
    endfunction

    // Row step of a direction's positive ray.
    function automatic logic signed [1:0] dir_dr(input logic [1:0] dir);
        logic signed [1:0] d;
        case (dir)
            DIR_HORZ:    d = DELTA_ZERO;
            DIR_VERT:    d = DELTA_POS;
            DIR_DIAG_UP: d = DELTA_POS;
            default:     d = DELTA_NEG;
        endcase
        return d;
    endfunction

    // Bottom line of a coin in the frame memory: row 0 sits at the bottom (31).
    function automatic logic [4:0] row_to_waddr(input logic [2:0] r);
        return 5'd31 - {r, 2'b00};
    endfunction

endpackage

// File: rtl/drop_controller_if.sv
// Move handshake and paint-memory bus of the drop controller.
interface drop_controller_if;
    import connect4_pkg::*;

    logic       move_valid;
    logic [2:0] move_col;
    logic       move_ready;
    logic       reject;
    logic       wen;
    logic [4:0] waddr;
    logic [2:0] colval;
    logic       Player;
    logic       win1;
    logic       win2;
    logic       draw;
    logic       busy;

    modport slave (
        input  move_valid, move_col,
        output move_ready, reject, wen, waddr, colval, Player,
               win1, win2, draw, busy
    );

    modport master (
        output move_valid, move_col,
        input  move_ready, reject, wen, waddr, colval, Player,
               win1, win2, draw, busy
    );
endinterface

// File: rtl/connect4_win_scanner.sv
// Walks the four line directions through the freshly landed coin, one probe per
// cycle, and reports whether any line reaches four of the same colour.
module connect4_win_scanner
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] origin_col,
    input  logic [2:0] origin_row,
    input  cell_t      colour,
    output logic [2:0] rd_col,
    output logic [2:0] rd_row,
    input  cell_t      rd_cell,
    output logic       done,
    output logic       win
);

    typedef enum logic {SC_IDLE, SC_PROBE} scan_state_t;

    localparam logic signed [4:0] MAX_COL = 5'(NUM_COLS - 1);
    localparam logic signed [4:0] MAX_ROW = 5'(NUM_ROWS - 1);

    scan_state_t state_reg, state_next;
    logic [1:0]  dir_reg, dir_next;
    logic        neg_reg, neg_next;
    logic [1:0]  step_reg, step_next;
    logic [1:0]  matches_reg, matches_next;
    logic [2:0]  col_reg, col_next;
    logic [2:0]  row_reg, row_next;
    cell_t       colour_reg, colour_next;
    logic        done_reg, done_next;
    logic        win_reg, win_next;

    logic signed [1:0] dc, dr;
    logic signed [4:0] dc_ext, dr_ext, step_ext;
    logic signed [4:0] off_c, off_r, probe_c, probe_r;
    logic              oob, hit, ray_end;

    // Probe address: origin plus step along the direction, mirrored on the negative ray
    always_comb begin
        dc       = dir_dc(dir_reg);
        dr       = dir_dr(dir_reg);
        dc_ext   = {{3{dc[1]}}, dc};
        dr_ext   = {{3{dr[1]}}, dr};
        step_ext = $signed({3'b000, step_reg});
        off_c    = dc_ext * step_ext;
        off_r    = dr_ext * step_ext;
        if (neg_reg) begin
            off_c = -off_c;
            off_r = -off_r;
        end
        probe_c = $signed({2'b00, col_reg}) + off_c;
        probe_r = $signed({2'b00, row_reg}) + off_r;
        oob     = (probe_c < 5'sd0) || (probe_c > MAX_COL) ||
                  (probe_r < 5'sd0) || (probe_r > MAX_ROW);
        hit     = !oob && (rd_cell == colour_reg);
    end

    assign rd_col = probe_c[2:0];
    assign rd_row = probe_r[2:0];
    assign done   = done_reg;
    assign win    = win_reg;

    // Ray/direction sequencing; matches counts both rays of the current direction
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        neg_next     = neg_reg;
        step_next    = step_reg;
        matches_next = matches_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        colour_next  = colour_reg;
        done_next    = 1'b0;
        win_next     = 1'b0;
        ray_end      = 1'b0;
        case (state_reg)
            SC_IDLE: begin
                if (start) begin
                    col_next     = origin_col;
                    row_next     = origin_row;
                    colour_next  = colour;
                    dir_next     = 2'd0;
                    neg_next     = 1'b0;
                    step_next    = 2'd1;
                    matches_next = 2'd0;
                    state_next   = SC_PROBE;
                end
            end
            SC_PROBE: begin
                if (hit && matches_reg == 2'd2) begin
                    // third neighbour found: run of four through the origin
                    done_next  = 1'b1;
                    win_next   = 1'b1;
                    state_next = SC_IDLE;
                end else if (hit && step_reg != 2'd3) begin
                    matches_next = matches_reg + 2'd1;
                    step_next    = step_reg + 2'd1;
                end else begin
                    ray_end = 1'b1;
                end
                if (ray_end) begin
                    step_next = 2'd1;
                    if (!neg_reg) begin
                        neg_next = 1'b1;
                    end else if (dir_reg == 2'd3) begin
                        done_next  = 1'b1;
                        state_next = SC_IDLE;
                    end else begin
                        dir_next     = dir_reg + 2'd1;
                        neg_next     = 1'b0;
                        matches_next = 2'd0;
                    end
                end
            end
        endcase
    end

    // Scanner state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= SC_IDLE;
            dir_reg     <= 2'd0;
            neg_reg     <= 1'b0;
            step_reg    <= 2'd1;
            matches_reg <= 2'd0;
            col_reg     <= 3'd0;
            row_reg     <= 3'd0;
            colour_reg  <= EMPTY;
            done_reg    <= 1'b0;
            win_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            neg_reg     <= neg_next;
            step_reg    <= step_next;
            matches_reg <= matches_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            colour_reg  <= colour_next;
            done_reg    <= done_next;
            win_reg     <= win_next;
        end
    end

endmodule

// File: rtl/drop_controller.sv
// Connect-4 move sequencer: accepts column requests, owns heights and the
// occupancy model, strobes the paint memory and tracks win/draw/turn.
module drop_controller
    import connect4_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    drop_controller_if.slave   bus
);

    logic clear;
    assign clear = rst | new_game;

    state_t     state_reg, state_next;
    logic [2:0] col_reg, col_next;
    logic [2:0] row_reg, row_next;
    logic       player_reg, player_next;
    logic       reject_reg, reject_next;
    logic       win1_reg, win1_next;
    logic       win2_reg, win2_next;
    logic       draw_reg, draw_next;
    logic [5:0] move_count_reg;

    logic [NUM_COLS-1:0][2:0]               height_all;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0][1:0] board_all;

    cell_t      player_coin;
    logic [2:0] sel_height;
    logic [2:0] scan_rd_col, scan_rd_row;
    cell_t      scan_rd_cell;
    logic       scan_done, scan_win;

    assign player_coin = player_reg ? P1 : P2;

    // Per-column occupancy model; the board is small enough to live in flops so
    // the scanner can read any cell in the same cycle it asks for it.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        logic [2:0]               height_reg;
        logic [NUM_ROWS-1:0][1:0] cells_reg;
        logic                     place_here;

        assign place_here = (state_reg == PLACE) && (col_reg == 3'(gi));

        // Coins stack from row 0 upward; a clear empties the column
        always_ff @(posedge clk) begin
            if (clear) begin
                height_reg <= 3'd0;
                cells_reg  <= '0;
            end else if (place_here) begin
                cells_reg[row_reg] <= player_coin;
                height_reg         <= height_reg + 3'd1;
            end
        end

        assign height_all[gi] = height_reg;
        assign board_all[gi]  = cells_reg;
    end

    assign sel_height = (bus.move_col != 3'd7) ? height_all[bus.move_col] : 3'(NUM_ROWS);

    assign scan_rd_cell = (scan_rd_col < 3'(NUM_COLS) && scan_rd_row < 3'(NUM_ROWS))
                          ? cell_t'(board_all[scan_rd_col][scan_rd_row]) : EMPTY;

    connect4_win_scanner u_scanner (
        .clk        (clk),
        .rst        (clear),
        .start      (state_reg == PLACE),
        .origin_col (col_reg),
        .origin_row (row_reg),
        .colour     (player_coin),
        .rd_col     (scan_rd_col),
        .rd_row     (scan_rd_row),
        .rd_cell    (scan_rd_cell),
        .done       (scan_done),
        .win        (scan_win)
    );

    // Move handshake, turn order and game-over decisions
    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        row_next    = row_reg;
        player_next = player_reg;
        reject_next = 1'b0;
        win1_next   = win1_reg;
        win2_next   = win2_reg;
        draw_next   = draw_reg;
        case (state_reg)
            IDLE: begin
                if (bus.move_valid) begin
                    if (bus.move_col == 3'd7 || sel_height == 3'(NUM_ROWS)) begin
                        reject_next = 1'b1;
                    end else begin
                        col_next   = bus.move_col;
                        row_next   = sel_height;
                        state_next = PLACE;
                    end
                end
            end
            PLACE: state_next = SCAN;
            SCAN: begin
                if (scan_done) begin
                    if (scan_win) begin
                        win1_next  = player_reg;
                        win2_next  = ~player_reg;
                        state_next = OVER;
                    end else if (move_count_reg == 6'(MAX_MOVES)) begin
                        draw_next  = 1'b1;
                        state_next = OVER;
                    end else begin
                        player_next = ~player_reg;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = OVER;
        endcase
    end

    // Controller state register; a restart has priority over every transition
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg  <= IDLE;
            col_reg    <= 3'd0;
            row_reg    <= 3'd0;
            player_reg <= 1'b1;
            reject_reg <= 1'b0;
            win1_reg   <= 1'b0;
            win2_reg   <= 1'b0;
            draw_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            player_reg <= player_next;
            reject_reg <= reject_next;
            win1_reg   <= win1_next;
            win2_reg   <= win2_next;
            draw_reg   <= draw_next;
        end
    end

    // Placement counter used for the full-board draw check
    always_ff @(posedge clk) begin
        if (clear) begin
            move_count_reg <= 6'd0;
        end else if (state_reg == PLACE) begin
            move_count_reg <= move_count_reg + 6'd1;
        end
    end

    assign bus.move_ready = (state_reg == IDLE);
    assign bus.busy       = (state_reg == PLACE) || (state_reg == SCAN);
    // A restart landing in PLACE also kills the strobe so no stray coin is painted.
    assign bus.wen        = (state_reg == PLACE) && !clear;
    assign bus.waddr      = row_to_waddr(row_reg);
    assign bus.colval     = col_reg;
    assign bus.Player     = player_reg;
    assign bus.reject     = reject_reg;
    assign bus.win1       = win1_reg;
    assign bus.win2       = win2_reg;
    assign bus.draw       = draw_reg;

endmodule
